// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the RAM arbiter slice.
package ram_arbiter_pkg;

  localparam int unsigned RAM_DEPTH = 256;

  typedef logic [7:0] ram_addr_t;
  typedef logic [7:0] ram_data_t;

  typedef enum logic {
    CLEAR = 1'b0,
    ARB   = 1'b1
  } arb_state_t;

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
module rr_pick #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   win_idx,
  output logic            found
);

  // Scan offsets 1..NREQ from last so that last itself has lowest priority.
  always_comb begin
    int unsigned idx;
    gnt     = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(last) + k) % NREQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        win_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and post-reset initialiser for the 256x8 single-port RAM.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned DEPTH     = RAM_DEPTH,
  parameter ram_data_t   CLEAR_VAL = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      we_i,
  input  ram_addr_t [NREQ-1:0] addr_i,
  input  ram_data_t [NREQ-1:0] wdata_i,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rvalid,
  output ram_data_t            rdata,
  output logic                 busy,
  output logic                 ram_ena,
  output logic                 ram_we,
  output ram_addr_t            ram_addr,
  output ram_data_t            ram_din,
  input  ram_data_t            ram_dout
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t      state_q, state_d;
  ram_addr_t       clr_cnt_q;
  logic [IW-1:0]   last_q;
  logic [NREQ-1:0] rvalid_q;

  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   win_idx;
  logic            found;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req     (req),
    .last    (last_q),
    .gnt     (pick_gnt),
    .win_idx (win_idx),
    .found   (found)
  );

  // Next state and RAM pin muxing; everything is held quiet while rst is high.
  always_comb begin
    state_d  = state_q;
    gnt      = '0;
    busy     = 1'b0;
    ram_ena  = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (rst) begin
      busy = 1'b1;
    end else begin
      case (state_q)
        CLEAR: begin
          busy     = 1'b1;
          ram_ena  = 1'b1;
          ram_we   = 1'b1;
          ram_addr = clr_cnt_q;
          ram_din  = CLEAR_VAL;
          if (clr_cnt_q == ram_addr_t'(DEPTH - 1)) state_d = ARB;
        end
        ARB: begin
          if (found) begin
            gnt      = pick_gnt;
            ram_ena  = 1'b1;
            ram_we   = we_i[win_idx];
            ram_addr = addr_i[win_idx];
            ram_din  = wdata_i[win_idx];
          end
        end
        default: state_d = CLEAR;
      endcase
    end
  end

  // State, clear counter, round-robin pointer and read-valid tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      last_q    <= IW'(NREQ - 1);
      rvalid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR) clr_cnt_q <= clr_cnt_q + 8'd1;
      if (gnt != '0) last_q <= win_idx;
      rvalid_q <= gnt & ~we_i;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural 256x8 synchronous RAM.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  localparam int unsigned NREQ = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req, we_i, gnt, rvalid;
  ram_addr_t [NREQ-1:0] addr_i;
  ram_data_t [NREQ-1:0] wdata_i;
  ram_data_t            rdata, ram_din, ram_dout;
  ram_addr_t            ram_addr;
  logic                 busy, ram_ena, ram_we;

  int total = 0;
  int bad   = 0;

  logic [1:0] gnt_q[$];
  logic [9:0] rv_q[$];
  logic [7:0] mem [0:255];

  always #5 clk = ~clk;

  ram_arbiter #(
    .NREQ      (NREQ),
    .DEPTH     (256),
    .CLEAR_VAL (8'h00)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .we_i     (we_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .busy     (busy),
    .ram_ena  (ram_ena),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  always @(posedge clk) begin
    if (ram_ena) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic w, input logic [7:0] a, input logic [7:0] d);
    req[r]     = 1'b1;
    we_i[r]    = w;
    addr_i[r]  = a;
    wdata_i[r] = d;
  endtask

  always @(negedge clk) begin : monitor
    logic [9:0] e;
    if (gnt !== '0) begin
      if (gnt_q.size() == 0) check("gnt_unexpected", 32'(gnt), 32'd0);
      else check("gnt_order", 32'(gnt), 32'(gnt_q.pop_front()));
    end
    if (rvalid !== '0) begin
      if (rv_q.size() == 0) check("rvalid_unexpected", 32'(rvalid), 32'd0);
      else begin
        e = rv_q.pop_front();
        check("rvalid_who", 32'(rvalid), 32'(e[9:8]));
        check("rdata", 32'(rdata), 32'(e[7:0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    req     = '0;
    we_i    = '0;
    addr_i  = '0;
    wdata_i = '0;
    tick();
    tick();
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_ram_pins", {ram_ena, ram_we, ram_addr, ram_din}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Clear sweep; requester 0 asks for a read of A5 partway through.
    for (int c = 0; c < 256; c++) begin
      if (c == 200) begin
        set_req(0, 1'b0, 8'hA5, 8'h00);
        gnt_q.push_back(2'b01);
        rv_q.push_back({2'b01, 8'h00});
      end
      @(negedge clk);
      check("clear_cycle", {busy, ram_ena, ram_we, gnt, ram_din, ram_addr},
            {1'b1, 1'b1, 1'b1, 2'b00, 8'h00, 8'(c)});
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("busy_fall", 32'(busy), 32'd0);
    check("first_read_pins", {ram_ena, ram_we, ram_addr}, {1'b1, 1'b0, 8'hA5});
    @(posedge clk);
    #1;
    req = '0;

    // Requester 1: write 3C to 10, then read it back.
    set_req(1, 1'b1, 8'h10, 8'h3C);
    gnt_q.push_back(2'b10);
    @(negedge clk);
    check("write_pins", {ram_we, ram_addr, ram_din}, {1'b1, 8'h10, 8'h3C});
    tick();
    set_req(1, 1'b0, 8'h10, 8'h00);
    gnt_q.push_back(2'b10);
    rv_q.push_back({2'b10, 8'h3C});
    tick();
    req = '0;
    tick();

    // Fairness: requester 1 writes 5A to 20, then both read for 6 cycles.
    set_req(1, 1'b1, 8'h20, 8'h5A);
    gnt_q.push_back(2'b10);
    tick();
    set_req(0, 1'b0, 8'h20, 8'h00);
    set_req(1, 1'b0, 8'h10, 8'h00);
    for (int i = 0; i < 3; i++) begin
      gnt_q.push_back(2'b01);
      rv_q.push_back({2'b01, 8'h5A});
      gnt_q.push_back(2'b10);
      rv_q.push_back({2'b10, 8'h3C});
    end
    for (int i = 0; i < 6; i++) tick();
    req = '0;

    // Contention after idle: last grant to 0, then both rise together.
    set_req(0, 1'b0, 8'h10, 8'h00);
    gnt_q.push_back(2'b01);
    rv_q.push_back({2'b01, 8'h3C});
    tick();
    req = '0;
    @(negedge clk);
    check("idle_bus", {ram_ena, ram_we, ram_addr, ram_din, gnt}, 32'd0);
    tick();
    tick();
    set_req(0, 1'b0, 8'h20, 8'h00);
    set_req(1, 1'b0, 8'h10, 8'h00);
    gnt_q.push_back(2'b10);
    rv_q.push_back({2'b10, 8'h3C});
    gnt_q.push_back(2'b01);
    rv_q.push_back({2'b01, 8'h5A});
    tick();
    req[1] = 1'b0;
    tick();
    req = '0;
    tick();
    tick();

    // Reset in the cycle a read would be granted.
    set_req(0, 1'b0, 8'h20, 8'h00);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_gnt", 32'(gnt), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd1);
    tick();
    rst = 1'b0;
    req = '0;
    @(negedge clk);
    check("rst_no_rvalid", 32'(rvalid), 32'd0);
    check("restart_addr0", {busy, ram_we, ram_addr}, {1'b1, 1'b1, 8'h00});
    tick();
    @(negedge clk);
    check("restart_addr1", 32'(ram_addr), 32'd1);
    tick();

    check("gnt_q_empty", 32'(gnt_q.size()), 32'd0);
    check("rv_q_empty", 32'(rv_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Round-robin arbiter and initialiser for the on-chip 256×8 single-port RAM (`rams`). It shares the RAM between NREQ requesters and sequences its `ena`/`we`/`addr`/`din` pins. After every reset it first clears the whole array to a fixed value, then grants at most one access per cycle. It sits in the system-bus layer of `marvin`, between the requesting modules and the RAM instance.

## Interface
Parameters:
- NREQ, 2: number of requesters (2..4).
- DEPTH, 256: RAM words; must equal 2**8 for the 8-bit address.
- CLEAR_VAL, 8'h00: word written to every address during the post-reset clear.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; synchronous and active-high (sampled on posedge clk).
- req  in  NREQ  per-requester access request; held until granted.
- we_i  in  NREQ  per-requester write flag (1 = write, 0 = read); valid while req.
- addr_i  in  NREQ×8  per-requester word address, packed (`ram_addr_t [NREQ-1:0]`).
- wdata_i  in  NREQ×8  per-requester write data, packed (`ram_data_t [NREQ-1:0]`).
- gnt  out  NREQ  one-hot acceptance strobe; combinational; at most one bit set.
- rvalid  out  NREQ  one-hot, registered; marks that rdata answers that requester's read.
- rdata  out  8  read data, broadcast to all requesters; qualified by rvalid.
- busy  out  1  high while the clear sequence runs.
- ram_ena  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  8  RAM address.
- ram_din  out  8  RAM write data.
- ram_dout  in  8  RAM read data; valid 1 cycle after the read edge.

## Operation
- FSM `arb_state_t` has 2 states, CLEAR and ARB. Reset value is CLEAR.
- **CLEAR state**
  - Each cycle drives ram_ena=1, ram_we=1, ram_addr=clr_cnt, ram_din=CLEAR_VAL; clr_cnt increments.
  - When clr_cnt==DEPTH-1 is written, the FSM goes to ARB next cycle and clr_cnt wraps to 0.
  - busy=1 and gnt=0 throughout; requests are ignored (held, not lost).
- **ARB state**
  - The winner is the first requester with req set, searched from (last+1) mod NREQ upward and wrapping.
  - Reset value of last is NREQ-1, so requester 0 has first priority.
  - When a winner i exists:
    - gnt[i]=1 and ram_ena=1.
    - ram_we=we_i[i], ram_addr=addr_i[i], ram_din=wdata_i[i].
    - last←i at the edge.
  - When no requester is set: gnt=0, ram_ena=0, ram_we=0, and ram_addr/ram_din are 0.
  - Read: at the edge after the grant, rvalid[i]←1 for one cycle and rdata=ram_dout.
  - Write: no rvalid is produced; gnt is the only acknowledgement.
- A requester may hold req for back-to-back accesses. With all requesters active, grants rotate 0,1,…,NREQ-1,0…
- Read-after-write to the same address by consecutive grants returns the new data, because the RAM write completes at the grant edge.
- Reset asserted mid-operation:
  - The FSM returns to CLEAR with clr_cnt=0, last=NREQ-1 and rvalid=0 at the next edge.
  - A read granted in the reset cycle produces no rvalid.
  - The clear sequence restarts from address 0.

## Timing
- Reset values: gnt=0, rvalid=0, rdata=ram_dout (passthrough; don't-care without rvalid), busy=1.
- RAM outputs during the reset cycle are ena=0, we=0, addr=0, din=0.
- Clear takes exactly DEPTH cycles: busy falls on the cycle DEPTH after rst deasserts, and the first gnt is possible that cycle.
- Grant latency is 0 cycles from req when uncontested.
- Read latency is 1 cycle from gnt to rvalid.
- Sustained throughput is 1 access/cycle.
- Worst-case wait for a continuously requesting port is NREQ-1 cycles.

## Structure
- Shared package `pkg` holds:
  - `ram_addr_t` (logic [7:0]) and `ram_data_t` (logic [7:0]);
  - `arb_state_t` enum {CLEAR, ARB};
  - constant `RAM_DEPTH = 256`.
- One combinational sub-module, `rr_pick`:
  - inputs: req vector and last index;
  - outputs: one-hot grant and encoded winner index.
- The FSM, clear counter, last-pointer and rvalid register stay in `ram_arbiter`.
- Expected size: about 150–250 lines of RTL.

## Test plan
- **Clear:** release rst, hold all req=0 → busy=1 for 256 cycles, with ram_we=1 and addresses 0..255 written as 8'h00. Then busy=0, and a read of address 8'hA5 returns 8'h00.
- **Requests during clear:** assert req[0] during clear → gnt stays 0 until busy falls, then gnt[0]=1 in that same cycle.
- **Write then read:**
  - requester 1 writes 8'h3C to address 8'h10 → gnt[1] pulses with no rvalid;
  - requester 1 then reads address 8'h10 → rvalid[1]=1 one cycle after gnt, rdata=8'h3C.
- **Fairness:** NREQ=2, both requesters holding req for 6 cycles → gnt sequence 0,1,0,1,0,1, and each rvalid matches its requester.
- **Contention after idle:** last grant went to 0, then req[0] and req[1] rise together → gnt[1] first, gnt[0] next cycle.
- **Reset mid-read:** assert rst in the cycle of a read gnt → no rvalid next cycle, busy=1, and the clear restarts at address 0.
